fifo_rd_ecc_stage: RTL

//  Read-side stage placed directly after the 16-entry FIFO controller and its raw memory.

---
 rtl/fifo_rd_ecc_stage_if.sv | 25 ++
 rtl/fifo_rd_ecc_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ecc_stage_if.sv
// Decoded-word valid/ready stream leaving the FIFO read ECC stage.
// The stage drives the master side; the consumer drives m_ready.
interface fifo_rd_ecc_stage_if;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sbe;
    logic       m_dbe;

    modport master (
        output m_valid,
        output m_data,
        output m_sbe,
        output m_dbe,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_sbe,
        input  m_dbe,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_ecc_stage.sv
// Read-side stage after the 16-entry FIFO: prefetches, SECDED-decodes and skid-buffers words.
// Optional error statistics counters are built only when ECC_STATS_EN is defined.
module fifo_rd_ecc_stage #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [12:0]          mem_rd_data,
    fifo_rd_ecc_stage_if.master  m,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     sbe_cnt,
    output logic [CNT_W-1:0]     dbe_cnt
);

    typedef struct packed {
        logic [7:0] data;
        logic       sbe;
        logic       dbe;
    } ecc_word_t;

    function automatic logic parity_f(input logic [12:0] code);
        return ^code;
    endfunction

    function automatic logic [3:0] syndrome_f(input logic [12:0] code);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            if (code[i]) begin
                s = s ^ 4'(i);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // Syndrome 0 with odd parity means only the overall parity bit flipped.
    function automatic ecc_word_t decode_f(input logic [12:0] code);
        ecc_word_t  r;
        logic [3:0] s;
        logic       p;
        logic [12:0] fixed;
        s     = syndrome_f(code);
        p     = parity_f(code);
        fixed = code;
        r.sbe = 1'b0;
        r.dbe = 1'b0;
        if (p == 1'b1) begin
            if (s <= 4'd12) begin
                fixed = code ^ (13'd1 << s);
                r.sbe = 1'b1;
            end else begin
                r.dbe = 1'b1;
            end
        end else begin
            if (s != 4'd0) begin
                r.dbe = 1'b1;
            end else begin
                r.dbe = 1'b0;
            end
        end
        r.data = {fixed[12], fixed[11], fixed[10], fixed[9],
                  fixed[7],  fixed[6],  fixed[5],  fixed[3]};
        return r;
    endfunction

    logic [1:0] occ_r;
    logic       pend_r;
    logic       run_r;
    ecc_word_t  slot0_r;
    ecc_word_t  slot1_r;
    ecc_word_t  dec_s;
    logic [1:0] credit_s;
    logic       push_s;
    logic       pop_s;

    assign dec_s    = decode_f(mem_rd_data);
    assign credit_s = occ_r + {1'b0, pend_r};
    assign push_s   = pend_r;
    assign pop_s    = (occ_r != 2'd0) && m.m_ready;

    // Read request: credits cover buffered words plus the one in flight; held off until out of reset.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (run_r && !fifo_empty && (credit_s < 2'd2)) begin
            fifo_rd_en = 1'b1;
        end else begin
            fifo_rd_en = 1'b0;
        end
    end

    // Read-issue tracking: pend marks memory data arriving next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
            run_r  <= 1'b0;
        end else begin
            pend_r <= fifo_rd_en;
            run_r  <= 1'b1;
        end
    end

    // Two-entry in-order skid buffer; slot0 is always the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r   <= 2'd0;
            slot0_r <= '{data: 8'h00, sbe: 1'b0, dbe: 1'b0};
            slot1_r <= '{data: 8'h00, sbe: 1'b0, dbe: 1'b0};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        slot0_r <= dec_s;
                    end else begin
                        slot1_r <= dec_s;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    occ_r   <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        slot0_r <= dec_s;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= dec_s;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign m.m_valid = (occ_r != 2'd0);
    assign m.m_data  = slot0_r.data;
    assign m.m_sbe   = slot0_r.sbe;
    assign m.m_dbe   = slot0_r.dbe;

`ifdef ECC_STATS_EN
    logic [CNT_W-1:0] sbe_cnt_r;
    logic [CNT_W-1:0] dbe_cnt_r;

    // Saturating error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_cnt_r <= {CNT_W{1'b0}};
            dbe_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            sbe_cnt_r <= {CNT_W{1'b0}};
            dbe_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (pop_s && slot0_r.sbe && (sbe_cnt_r != {CNT_W{1'b1}})) begin
                sbe_cnt_r <= sbe_cnt_r + CNT_W'(1);
            end
            if (pop_s && slot0_r.dbe && (dbe_cnt_r != {CNT_W{1'b1}})) begin
                dbe_cnt_r <= dbe_cnt_r + CNT_W'(1);
            end
        end
    end

    assign sbe_cnt = sbe_cnt_r;
    assign dbe_cnt = dbe_cnt_r;
`else
    logic unused_cnt_clr_s;

    assign unused_cnt_clr_s = cnt_clr;
    assign sbe_cnt          = {CNT_W{1'b0}};
    assign dbe_cnt          = {CNT_W{1'b0}};
`endif

endmodule
